// File: rtl/sigmag_pkg.sv
// Shared types, constants and helpers for the sign/magnitude statistics monitor.
package sigmag_pkg;

  localparam int PCT_WIDTH   = 7;
  localparam int THR_SAT_MIN = 1;

  typedef enum logic [1:0] {
    AGC_HOLD = 2'd0,
    AGC_UP   = 2'd1,
    AGC_DOWN = 2'd2
  } agc_dir_e;

  function automatic int thr_sat_max(input int thr_width);
    return (1 << thr_width) - 1;
  endfunction

  // Full-precision cnt*100 followed by a truncating shift; the result never exceeds 100.
  function automatic logic [PCT_WIDTH-1:0] pct_of(input logic [31:0] cnt, input int cntr_size);
    logic [31:0] prod;
    prod = cnt * 32'd100;
    prod = prod >> cntr_size;
    return prod[PCT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sigmag_agc_step.sv
// Threshold AGC: one saturating step of thr per published window, driven by mag_pct.
module sigmag_agc_step
  import sigmag_pkg::*;
#(
  parameter int THR_WIDTH  = 13,
  parameter int THR_INIT   = 1024,
  parameter int THR_STEP   = 16,
  parameter int TARGET_PCT = 33,
  parameter int HYST_PCT   = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stat_valid,
  input  logic [PCT_WIDTH-1:0] mag_pct,
  output logic [THR_WIDTH-1:0] thr
);

  localparam int PCT_HI  = TARGET_PCT + HYST_PCT;
  localparam int PCT_LO  = TARGET_PCT - HYST_PCT;
  localparam int THR_MAX = thr_sat_max(THR_WIDTH);

  logic [THR_WIDTH-1:0] thr_q, thr_d;
  agc_dir_e             dir;
  int                   mag_pct_i;
  int                   thr_next;

  always_comb begin
    mag_pct_i = int'(mag_pct);
    dir       = AGC_HOLD;
    if (mag_pct_i > PCT_HI) begin
      dir = AGC_UP;
    end else if (mag_pct_i < PCT_LO) begin
      dir = AGC_DOWN;
    end
  end

  always_comb begin
    thr_next = int'(thr_q);
    case (dir)
      AGC_UP:   thr_next = int'(thr_q) + THR_STEP;
      AGC_DOWN: thr_next = int'(thr_q) - THR_STEP;
      default:  thr_next = int'(thr_q);
    endcase
    if (thr_next > THR_MAX) begin
      thr_next = THR_MAX;
    end else if (thr_next < THR_SAT_MIN) begin
      thr_next = THR_SAT_MIN;
    end
    thr_d = thr_q;
    if (stat_valid) begin
      thr_d = THR_WIDTH'(thr_next);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thr_q <= THR_WIDTH'(THR_INIT);
    end else begin
      thr_q <= thr_d;
    end
  end

  assign thr = thr_q;

endmodule

// File: rtl/sigmag_monitor.sv
// Windowed sig/mag ones counter with percentage outputs and optional threshold AGC.
// Define SIGMAG_MONITOR_AGC_EN to build the AGC loop; otherwise thr is the constant THR_INIT.
module sigmag_monitor
  import sigmag_pkg::*;
#(
  parameter int CNTR_SIZE  = 12,
  parameter int THR_WIDTH  = 13,
  parameter int THR_INIT   = 1024,
  parameter int THR_STEP   = 16,
  parameter int TARGET_PCT = 33,
  parameter int HYST_PCT   = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 sig,
  input  logic                 mag,
  input  logic                 clr,
  output logic [CNTR_SIZE:0]   sig_cnt,
  output logic [CNTR_SIZE:0]   mag_cnt,
  output logic [PCT_WIDTH-1:0] sig_pct,
  output logic [PCT_WIDTH-1:0] mag_pct,
  output logic                 stat_valid,
  output logic [THR_WIDTH-1:0] thr
);

  localparam logic [CNTR_SIZE-1:0] WIN_LAST = '1;

  logic [CNTR_SIZE-1:0] win_cnt_q, win_cnt_d;
  logic [CNTR_SIZE:0]   sig_acc_q, sig_acc_d;
  logic [CNTR_SIZE:0]   mag_acc_q, mag_acc_d;
  logic [CNTR_SIZE:0]   sig_cnt_q, sig_cnt_d;
  logic [CNTR_SIZE:0]   mag_cnt_q, mag_cnt_d;
  logic [PCT_WIDTH-1:0] sig_pct_q, sig_pct_d;
  logic [PCT_WIDTH-1:0] mag_pct_q, mag_pct_d;
  logic                 stat_valid_q, stat_valid_d;
  logic [CNTR_SIZE:0]   sig_sum, mag_sum;

  // The sums include the current sample so the window's last sample lands in the published counts.
  assign sig_sum = sig_acc_q + {{CNTR_SIZE{1'b0}}, sig};
  assign mag_sum = mag_acc_q + {{CNTR_SIZE{1'b0}}, mag};

  always_comb begin
    win_cnt_d    = win_cnt_q;
    sig_acc_d    = sig_acc_q;
    mag_acc_d    = mag_acc_q;
    sig_cnt_d    = sig_cnt_q;
    mag_cnt_d    = mag_cnt_q;
    sig_pct_d    = sig_pct_q;
    mag_pct_d    = mag_pct_q;
    stat_valid_d = 1'b0;
    if (clr) begin
      win_cnt_d = '0;
      sig_acc_d = '0;
      mag_acc_d = '0;
    end else if (en) begin
      win_cnt_d = win_cnt_q + 1'b1;
      if (win_cnt_q == WIN_LAST) begin
        sig_cnt_d    = sig_sum;
        mag_cnt_d    = mag_sum;
        sig_pct_d    = pct_of(32'(sig_sum), CNTR_SIZE);
        mag_pct_d    = pct_of(32'(mag_sum), CNTR_SIZE);
        stat_valid_d = 1'b1;
        sig_acc_d    = '0;
        mag_acc_d    = '0;
      end else begin
        sig_acc_d = sig_sum;
        mag_acc_d = mag_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_cnt_q    <= '0;
      sig_acc_q    <= '0;
      mag_acc_q    <= '0;
      sig_cnt_q    <= '0;
      mag_cnt_q    <= '0;
      sig_pct_q    <= '0;
      mag_pct_q    <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      sig_acc_q    <= sig_acc_d;
      mag_acc_q    <= mag_acc_d;
      sig_cnt_q    <= sig_cnt_d;
      mag_cnt_q    <= mag_cnt_d;
      sig_pct_q    <= sig_pct_d;
      mag_pct_q    <= mag_pct_d;
      stat_valid_q <= stat_valid_d;
    end
  end

  assign sig_cnt    = sig_cnt_q;
  assign mag_cnt    = mag_cnt_q;
  assign sig_pct    = sig_pct_q;
  assign mag_pct    = mag_pct_q;
  assign stat_valid = stat_valid_q;

`ifdef SIGMAG_MONITOR_AGC_EN
  sigmag_agc_step #(
    .THR_WIDTH (THR_WIDTH),
    .THR_INIT  (THR_INIT),
    .THR_STEP  (THR_STEP),
    .TARGET_PCT(TARGET_PCT),
    .HYST_PCT  (HYST_PCT)
  ) u_agc (
    .clk       (clk),
    .resetn    (resetn),
    .stat_valid(stat_valid_q),
    .mag_pct   (mag_pct_q),
    .thr       (thr)
  );
`else
  assign thr = THR_WIDTH'(THR_INIT);
`endif

endmodule

// File: tb/tb_sigmag_monitor.sv
// Scoreboard bench for sigmag_monitor: windows are driven sample by sample, expectations queued per window.
module tb_sigmag_monitor;

`ifdef SIGMAG_MONITOR_AGC_EN
  localparam bit AGC_ON = 1'b1;
`else
  localparam bit AGC_ON = 1'b0;
`endif
  localparam int SAT_INIT = 8185;
  localparam int SAT_HI   = AGC_ON ? 8191 : SAT_INIT;

  typedef struct {
    int sig_cnt;
    int mag_cnt;
    int sig_pct;
    int mag_pct;
    int thr;
    int sat_thr;
    int gap_min;
    int gap_max;
  } exp_t;

  logic        clk, resetn, en, sig, mag, clr;
  logic [12:0] sig_cnt, mag_cnt, sat_sig_cnt, sat_mag_cnt;
  logic [6:0]  sig_pct, mag_pct, sat_sig_pct, sat_mag_pct;
  logic        stat_valid, sat_stat_valid;
  logic [12:0] thr, sat_thr;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_sv_cyc = 0;
  bit   mon_busy = 1'b0;

  sigmag_monitor u_dut (
    .clk(clk), .resetn(resetn), .en(en), .sig(sig), .mag(mag), .clr(clr),
    .sig_cnt(sig_cnt), .mag_cnt(mag_cnt), .sig_pct(sig_pct), .mag_pct(mag_pct),
    .stat_valid(stat_valid), .thr(thr)
  );

  // Second instance with mag held high and a threshold preloaded near the top of its range.
  sigmag_monitor #(.THR_INIT(SAT_INIT)) u_sat (
    .clk(clk), .resetn(resetn), .en(en), .sig(sig), .mag(1'b1), .clr(clr),
    .sig_cnt(sat_sig_cnt), .mag_cnt(sat_mag_cnt), .sig_pct(sat_sig_pct), .mag_pct(sat_mag_pct),
    .stat_valid(sat_stat_valid), .thr(sat_thr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_thr(input int agc_val);
    return AGC_ON ? agc_val : 1024;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic e, input logic s, input logic m, input logic c);
    en  = e;
    sig = s;
    mag = m;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check_output("rst_sig_cnt", int'(sig_cnt), 0);
    check_output("rst_mag_cnt", int'(mag_cnt), 0);
    check_output("rst_sig_pct", int'(sig_pct), 0);
    check_output("rst_mag_pct", int'(mag_pct), 0);
    check_output("rst_stat_valid", int'(stat_valid), 0);
    check_output("rst_thr", int'(thr), 1024);
    check_output("rst_sat_thr", int'(sat_thr), SAT_INIT);
  endtask

  // Monitor: pops one expectation per stat_valid pulse, then checks thr one clock later.
  initial begin
    exp_t e;
    int   gap;
    forever begin
      @(negedge clk);
      if (stat_valid) begin
        mon_busy = 1'b1;
        gap = cyc - last_sv_cyc;
        last_sv_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_stat_valid: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("sig_cnt", int'(sig_cnt), e.sig_cnt);
          check_output("mag_cnt", int'(mag_cnt), e.mag_cnt);
          check_output("sig_pct", int'(sig_pct), e.sig_pct);
          check_output("mag_pct", int'(mag_pct), e.mag_pct);
          if (e.gap_min > 0) begin
            check_output("stat_gap_in_range", int'(gap >= e.gap_min && gap <= e.gap_max), 1);
          end
          @(negedge clk);
          check_output("stat_valid_one_cycle", int'(stat_valid), 0);
          check_output("thr", int'(thr), e.thr);
          check_output("sat_thr", int'(sat_thr), e.sat_thr);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    resetn = 1'b0;
    en = 1'b0; sig = 1'b0; mag = 1'b0; clr = 1'b0;
    #12;
    check_reset_state();
    @(negedge clk);
    resetn = 1'b1;

    // mag on every 3rd sample from sample 0, sig on the first 1000 samples
    exp_q.push_back('{sig_cnt:1000, mag_cnt:1366, sig_pct:24, mag_pct:33,
                      thr:1024, sat_thr:SAT_HI, gap_min:0, gap_max:0});
    for (int i = 0; i < 4096; i++) apply_stimulus(1'b1, i < 1000, (i % 3) == 0, 1'b0);

    // all-ones sig window
    exp_q.push_back('{sig_cnt:4096, mag_cnt:0, sig_pct:100, mag_pct:0,
                      thr:exp_thr(1008), sat_thr:SAT_HI, gap_min:0, gap_max:0});
    for (int i = 0; i < 4096; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // 50% en duty; mag is high only while en is low and must not count
    exp_q.push_back('{sig_cnt:4096, mag_cnt:0, sig_pct:100, mag_pct:0,
                      thr:exp_thr(992), sat_thr:SAT_HI, gap_min:8191, gap_max:8192});
    for (int i = 0; i < 4096; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    end

    // clr at window sample 2000 discards the partial window and the coinciding sample
    exp_q.push_back('{sig_cnt:4096, mag_cnt:0, sig_pct:100, mag_pct:0,
                      thr:exp_thr(976), sat_thr:SAT_HI, gap_min:0, gap_max:0});
    for (int i = 0; i < 2000; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    check_output("held_sig_cnt", int'(sig_cnt), 4096);
    check_output("held_mag_cnt", int'(mag_cnt), 0);
    check_output("held_sig_pct", int'(sig_pct), 100);
    check_output("held_thr", int'(thr), exp_thr(992));
    for (int i = 0; i < 4096; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // clr on the last sample of a window: no pulse may appear for it
    for (int i = 0; i < 4095; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // alternating sig, mag on the first quarter
    exp_q.push_back('{sig_cnt:2048, mag_cnt:1024, sig_pct:50, mag_pct:25,
                      thr:exp_thr(960), sat_thr:SAT_HI, gap_min:0, gap_max:0});
    for (int i = 0; i < 4096; i++) apply_stimulus(1'b1, (i % 2) == 1, i < 1024, 1'b0);

    // reset mid-window, then a full all-mag window
    for (int i = 0; i < 3000; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    resetn = 1'b0;
    #2;
    check_reset_state();
    @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back('{sig_cnt:0, mag_cnt:4096, sig_pct:0, mag_pct:100,
                      thr:exp_thr(1040), sat_thr:SAT_HI, gap_min:0, gap_max:0});
    for (int i = 0; i < 4096; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_output("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sigmag_monitor.md
# sigmag_monitor

Statistics and threshold-control stage placed directly downstream of the 2-bit sign/magnitude quantizer. It counts `sig` and `mag` ones over a fixed window of 2^CNTR_SIZE samples and publishes counts and integer percentages once per window. Optionally, it closes an AGC loop by stepping the quantizer magnitude threshold toward a target `mag` duty.

## Interface
Parameters:
- CNTR_SIZE, 12, log2 of window length in samples
- THR_WIDTH, 13, threshold width (unsigned, matches |data| range of 14-bit input)
- THR_INIT, 1024, threshold value after reset
- THR_STEP, 16, threshold increment/decrement per window
- TARGET_PCT, 33, desired mag percentage
- HYST_PCT, 3, dead band half-width in percent

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- en  in  1  sample strobe; sig/mag sampled only when high
- sig  in  1  quantizer sign bit
- mag  in  1  quantizer magnitude bit
- clr  in  1  synchronous window restart
- sig_cnt  out  CNTR_SIZE+1  sig ones in last completed window
- mag_cnt  out  CNTR_SIZE+1  mag ones in last completed window
- sig_pct  out  7  (sig_cnt*100)>>CNTR_SIZE
- mag_pct  out  7  (mag_cnt*100)>>CNTR_SIZE
- stat_valid  out  1  one-cycle pulse, new statistics present
- thr  out  THR_WIDTH  magnitude threshold fed back to quantizer

## Operation
- Window counter (CNTR_SIZE bits) increments on each `en`; wraps from 2^CNTR_SIZE-1 to 0.
- Accumulators are CNTR_SIZE+1 bits wide, so an all-ones window (2^CNTR_SIZE) does not overflow.
- The last sample of a window is included in the published counts. The accumulators restart at that sample's value being dropped, i.e. they restart at 0 for the next window. No sample is lost across the boundary.
- Percent: full-precision product cnt*100, truncating right shift by CNTR_SIZE. Maximum value is 100.
- AGC (when compiled in), evaluated on the cycle after stat_valid:
  - mag_pct > TARGET_PCT+HYST_PCT: thr += THR_STEP
  - mag_pct < TARGET_PCT-HYST_PCT: thr -= THR_STEP
  - otherwise hold
  - saturate to [1, 2^THR_WIDTH-1]
- clr: zeroes the window counter and accumulators. It does not touch published outputs or thr. If clr coincides with en, clr wins and the sample is discarded.
- clr coinciding with the window's last en: the window is discarded and there is no stat_valid.

## Timing
- Reset values: sig_cnt, mag_cnt, sig_pct, mag_pct, stat_valid = 0; thr = THR_INIT.
- stat_valid asserts exactly 1 clk after the clock edge that samples the window's last `en`. All four statistic outputs update on that same edge and hold until the next stat_valid.
- thr updates 1 clk after stat_valid, i.e. 2 clk after the last sample.
- Gaps in `en` stretch the window. The window length is always counted in samples, not clocks.
- Reset mid-window: all state returns to reset values. The first window after reset is full length.

## Configuration
- SIGMAG_MONITOR_AGC_EN defined: the AGC step logic is instantiated and thr tracks as above.
- Undefined: thr is constant THR_INIT, no AGC logic is synthesized, and statistics behaviour is identical.

## Structure
- Package `sigmag_pkg` holds:
  - PCT_WIDTH = 7
  - the percent function (cnt, CNTR_SIZE)
  - the threshold saturation bounds
- Sub-module `sigmag_agc_step` contains the comparator, step logic and saturating register for thr. It is instantiated only under SIGMAG_MONITOR_AGC_EN.

## Test plan
- en=1, sig=1, mag=0 for 4096 samples -> stat_valid pulse; sig_cnt=4096, sig_pct=100, mag_cnt=0, mag_pct=0; with AGC, thr 1024→1008.
- mag high on every 3rd sample starting at window sample 0 -> mag_cnt=1366, mag_pct=33; thr holds at 1024.
- en toggling 1/0 (50% duty) with sig=1 -> stat_valid arrives 8191–8192 clocks apart; sig_cnt=4096.
- clr pulsed at window sample 2000 with sig=1 -> next stat_valid occurs 4096 samples after clr, sig_cnt=4096; previous outputs are held until then.
- mag=1 constantly with thr preloaded by THR_INIT=8185 -> thr saturates at 8191 after one window and stays there.
- resetn asserted at window sample 3000 -> all outputs 0, thr=1024; first stat_valid comes 4096 samples after reset release.
